adc_lvds_emulator: RTL and testbench
====================================

// Module: adc_lvds_emulator
// PURPOSE
//  Fabric-level transmitter that emulates the two-lane-per-channel serial ADC output for one channel:
//  serialises 16-bit sample words onto lanes d1/d0 and generates the matching frame clock.
//  Drives the deserializer/frame-detector/bitslip receive path in loopback benches and on hardware.
//  Runs at bit rate, one bit per lane per clock. An 8-cycle frame carries one word.
//  Provides a sync-pattern preamble, a one-bit skew injector and underrun reporting.
// PARAMETERS
//  DATA_WIDTH    16       sample width, 14 or 16; 14-bit words are left-justified, W = {s_data, 2'b00}
//  SYNC_FRAMES   16       number of SYNC_PATTERN frames sent after en rises, 1..255
//  SYNC_PATTERN  16'hA55A word repeated during the SYNC state
// PORTS
//  CLK          in   1           bit-rate clock
//  RST          in   1           asynchronous, active-high reset
//  en           in   1           transmit enable (level)
//  s_data       in   DATA_WIDTH  sample word
//  s_valid      in   1           s_data valid
//  s_ready      out  1           holding register can accept a word
//  skew_req     in   1           pulse: insert one blank bit slot at the next frame boundary
//  d1           out  1           lane 1 serial data
//  d0           out  1           lane 0 serial data
//  fco          out  1           frame clock
//  frame_start  out  1           high in the cycle that slot 0 is on d1/d0/fco
//  underrun     out  1           one-cycle pulse, data frame sent with no word available
// BEHAVIOUR
//  - Reset: state IDLE. d1, d0, fco, frame_start, underrun, s_ready = 0. Holding register empty. Slot counter = 0.
//  - All outputs are registered. Slot counter runs 0..7 and wraps. The frame boundary is the cycle in which slot 7 is on the outputs.
//  - Bit mapping, slot k (0..7): d1 = W[15-2k], d0 = W[14-2k]. The word is sent MSB-first; d1 carries odd bits, d0 carries even bits.
//  - fco = 1 in slots 0-3 and 0 in slots 4-7 (0xF0 per frame).
//  - The shift register loads the next word at the frame boundary. Its first bits appear the following cycle, with frame_start = 1.
//  - FSM states:
//    - IDLE: outputs 0, counter held at 0. en = 1 -> SYNC next cycle; slot 0 is output the cycle after that.
//    - SYNC: sends SYNC_PATTERN for SYNC_FRAMES frames, then DATA at a frame boundary.
//    - DATA: at each boundary, loads the holding register if it is full. Otherwise loads 0 and pulses underrun together with frame_start.
//    - en = 0 in SYNC or DATA: the current frame completes, then IDLE at the boundary. The holding register is cleared on entry to IDLE.
//  - s_ready = (state != IDLE) && holding register empty. A word is accepted on s_valid && s_ready.
//    - In SYNC, the first word is prefetched so the first data frame does not underrun.
//    - A word accepted in the boundary cycle is not loaded until the next boundary.
//    - Sustained rate: one word per 8 cycles, no gaps.
//  - skew_req: a request is latched and serviced at the next frame boundary. Service inserts one extra cycle with d1 = d0 = fco = 0 before slot 0. That one frame is 9 cycles long, giving the receiver a one-bit alignment shift.
//    - Requests arriving while one is pending are coalesced.
//    - A request in the boundary cycle itself applies to the following boundary.
//    - A request in IDLE is discarded.
//  - RST asserted mid-frame: all outputs go to reset values immediately (asynchronous). The frame is abandoned.
//  - skew_req and underrun are independent; both can occur on the same boundary.
// TESTING
//  1. Reset, then en = 1 -> cycle 2 onward: fco = 1111_0000 repeating. Per frame d1 = 1,1,0,0,0,0,1,1 and d0 = 0,0,1,1,1,1,0,0. DATA entered after 16 frames (128 cycles).
//  2. DATA, push 16'h8001 -> d1 = 1,0,0,0,0,0,0,0 and d0 = 0,0,0,0,0,0,0,1. frame_start high with slot 0.
//  3. s_valid held high with 0x1234, 0x5678, 0x9ABC -> three consecutive frames, no gap, no underrun. s_ready low 7 of every 8 cycles.
//  4. DATA, s_valid = 0 -> d1 = d0 = 0 for the frame. underrun = 1 for exactly one cycle, coincident with frame_start.
//  5. skew_req pulse in slot 3 -> following frame preceded by one blank cycle; fco period 9 once, then 8. Two pulses in one frame -> only one slot inserted.
//  6. en = 0 at slot 2 -> slots 3-7 still sent, then outputs 0 and s_ready = 0. RST at slot 5 -> all outputs 0 the same cycle.

Source files
------------

// File: rtl/adc_lvds_emulator.sv
// Two-lane serial ADC output emulator for one channel: 16-bit words over d1/d0 in 8-slot frames,
// with frame clock, sync preamble, one-slot skew injection and underrun reporting.
module adc_lvds_emulator #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned SYNC_FRAMES  = 16,
  parameter logic [15:0] SYNC_PATTERN = 16'hA55A
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  skew_req,
  output logic                  d1,
  output logic                  d0,
  output logic                  fco,
  output logic                  frame_start,
  output logic                  underrun
);

  typedef enum logic [1:0] {StIdle, StSync, StData} state_e;

  state_e      state_q, state_d;
  logic [2:0]  slot_q, slot_d;
  logic        emit_q, emit_d;
  logic        blank_q, blank_d;
  logic [15:0] shreg_q, shreg_d;
  logic [15:0] hold_q, hold_d;
  logic        full_q, full_d;
  logic        skew_pend_q, skew_pend_d;
  logic        ur_pend_q, ur_pend_d;
  logic [7:0]  sync_cnt_q, sync_cnt_d;
  logic        d1_q, d1_d, d0_q, d0_d, fco_q, fco_d;
  logic        fs_q, fs_d, ur_q, ur_d, rdy_q, rdy_d;
  logic [15:0] load_word;
  logic        load_uf;
  logic        go_idle;

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    emit_d      = emit_q;
    blank_d     = 1'b0;
    shreg_d     = shreg_q;
    hold_d      = hold_q;
    full_d      = full_q;
    skew_pend_d = skew_pend_q;
    ur_pend_d   = ur_pend_q;
    sync_cnt_d  = sync_cnt_q;
    d1_d        = 1'b0;
    d0_d        = 1'b0;
    fco_d       = 1'b0;
    fs_d        = 1'b0;
    ur_d        = 1'b0;
    load_word   = '0;
    load_uf     = 1'b0;
    go_idle     = 1'b0;

    // Narrow words are left-justified into the 16-bit frame.
    if (s_valid && rdy_q) begin
      hold_d = 16'(s_data) << (16 - DATA_WIDTH);
      full_d = 1'b1;
    end
    if (state_q != StIdle && skew_req) skew_pend_d = 1'b1;

    if (state_q == StIdle) begin
      slot_d     = 3'd0;
      emit_d     = 1'b0;
      sync_cnt_d = 8'd0;
      if (en) state_d = StSync;
    end else if (emit_q && slot_q != 3'd7) begin
      slot_d  = slot_q + 3'd1;
      d1_d    = shreg_q[15];
      d0_d    = shreg_q[14];
      fco_d   = (slot_q < 3'd3);
      shreg_d = {shreg_q[13:0], 2'b00};
    end else if (blank_q) begin
      // Word was chosen at the boundary before the blank slot.
      slot_d  = 3'd0;
      emit_d  = 1'b1;
      d1_d    = shreg_q[15];
      d0_d    = shreg_q[14];
      fco_d   = 1'b1;
      fs_d    = 1'b1;
      ur_d    = ur_pend_q;
      shreg_d = {shreg_q[13:0], 2'b00};
    end else if (!en) begin
      go_idle = 1'b1;
    end else begin
      if (state_q == StSync && sync_cnt_q < 8'(SYNC_FRAMES)) begin
        load_word  = SYNC_PATTERN;
        sync_cnt_d = sync_cnt_q + 8'd1;
      end else begin
        state_d = StData;
        if (full_q) begin
          load_word = hold_q;
          full_d    = 1'b0;
        end else begin
          load_uf = 1'b1;
        end
      end
      // The first frame after IDLE is not a boundary, so skew is never serviced there.
      if (emit_q && skew_pend_q) begin
        blank_d     = 1'b1;
        emit_d      = 1'b0;
        slot_d      = 3'd0;
        shreg_d     = load_word;
        ur_pend_d   = load_uf;
        skew_pend_d = skew_req;
      end else begin
        slot_d  = 3'd0;
        emit_d  = 1'b1;
        d1_d    = load_word[15];
        d0_d    = load_word[14];
        fco_d   = 1'b1;
        fs_d    = 1'b1;
        ur_d    = load_uf;
        shreg_d = {load_word[13:0], 2'b00};
      end
    end

    if (go_idle) begin
      state_d     = StIdle;
      slot_d      = 3'd0;
      emit_d      = 1'b0;
      blank_d     = 1'b0;
      full_d      = 1'b0;
      skew_pend_d = 1'b0;
      sync_cnt_d  = 8'd0;
    end

    rdy_d = (state_d != StIdle) && !full_d;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= StIdle;
      slot_q      <= 3'd0;
      emit_q      <= 1'b0;
      blank_q     <= 1'b0;
      shreg_q     <= '0;
      hold_q      <= '0;
      full_q      <= 1'b0;
      skew_pend_q <= 1'b0;
      ur_pend_q   <= 1'b0;
      sync_cnt_q  <= 8'd0;
      d1_q        <= 1'b0;
      d0_q        <= 1'b0;
      fco_q       <= 1'b0;
      fs_q        <= 1'b0;
      ur_q        <= 1'b0;
      rdy_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      emit_q      <= emit_d;
      blank_q     <= blank_d;
      shreg_q     <= shreg_d;
      hold_q      <= hold_d;
      full_q      <= full_d;
      skew_pend_q <= skew_pend_d;
      ur_pend_q   <= ur_pend_d;
      sync_cnt_q  <= sync_cnt_d;
      d1_q        <= d1_d;
      d0_q        <= d0_d;
      fco_q       <= fco_d;
      fs_q        <= fs_d;
      ur_q        <= ur_d;
      rdy_q       <= rdy_d;
    end
  end

  assign d1          = d1_q;
  assign d0          = d0_q;
  assign fco         = fco_q;
  assign frame_start = fs_q;
  assign underrun    = ur_q;
  assign s_ready     = rdy_q;

endmodule

// File: tb/tb_adc_lvds_emulator.sv
// Bench for adc_lvds_emulator: frame-level reference model compared every cycle, plus
// hand-computed checks on frame timing, recovered words, skew and async reset.
module tb_adc_lvds_emulator;

  localparam int SyncFrames = 16;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        en = 1'b0;
  logic [15:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        skew_req = 1'b0;
  logic        d1, d0, fco, frame_start, underrun;

  adc_lvds_emulator #(
    .DATA_WIDTH  (16),
    .SYNC_FRAMES (SyncFrames),
    .SYNC_PATTERN(16'hA55A)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .en         (en),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .skew_req   (skew_req),
    .d1         (d1),
    .d0         (d0),
    .fco        (fco),
    .frame_start(frame_start),
    .underrun   (underrun)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Reference model: whole frames are queued as cycle entries {d1,d0,fco,frame_start,underrun}.
  logic [4:0]  m_q[$];
  logic [4:0]  exp_o = '0;
  logic        exp_rdy = 1'b0;
  int          m_state = 0;  // 0 idle, 1 sync, 2 data
  int          m_sync = 0;
  logic        m_full = 1'b0;
  logic [15:0] m_hold = '0;
  logic        m_pend = 1'b0;
  logic        m_started = 1'b0;
  logic        m_acc, m_skw, m_uf;
  logic [15:0] m_word;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_q.delete();
      exp_o   = '0;
      exp_rdy = 1'b0;
      m_state = 0;
      m_sync  = 0;
      m_full  = 1'b0;
      m_pend  = 1'b0;
    end else begin
      m_acc = s_valid && exp_rdy;
      m_skw = skew_req && (m_state != 0);
      if (m_state == 0) begin
        exp_o = '0;
        if (en) begin
          m_state   = 1;
          m_sync    = 0;
          m_started = 1'b0;
        end
      end else begin
        if (m_q.size() == 0) begin
          if (!en) begin
            m_state = 0;
            m_full  = 1'b0;
            m_pend  = 1'b0;
          end else begin
            m_uf = 1'b0;
            if (m_state == 1 && m_sync < SyncFrames) begin
              m_word = 16'hA55A;
              m_sync++;
            end else begin
              m_state = 2;
              if (m_full) begin
                m_word = m_hold;
                m_full = 1'b0;
              end else begin
                m_word = '0;
                m_uf   = 1'b1;
              end
            end
            if (m_pend && m_started) begin
              m_q.push_back(5'b0);
              m_pend = 1'b0;
            end
            for (int k = 0; k < 8; k++)
              m_q.push_back({m_word[15-2*k], m_word[14-2*k], k < 4, k == 0, k == 0 && m_uf});
            m_started = 1'b1;
          end
        end
        exp_o = (m_q.size() != 0) ? m_q.pop_front() : 5'b0;
        if (m_state != 0) begin
          if (m_acc) begin
            m_hold = s_data;
            m_full = 1'b1;
          end
          if (m_skw) m_pend = 1'b1;
        end
      end
      exp_rdy = (m_state != 0) && !m_full;
    end
  end

  always @(negedge CLK) begin
    n_tests++;
    if ({d1, d0, fco, frame_start, underrun, s_ready} !== {exp_o, exp_rdy}) begin
      n_fail++;
      $display("FAIL cycle_compare cyc=%0d got d1,d0,fco,fs,ur,rdy=%b required=%b", cyc,
               {d1, d0, fco, frame_start, underrun, s_ready}, {exp_o, exp_rdy});
    end
  end

  // Frame monitor: records frame_start/underrun cycles and recovers the word of each frame.
  int          fs_cyc[$];
  int          ur_cyc[$];
  logic [15:0] words[$];
  logic [7:0]  fco_b[$];
  int          cap_k = 8;
  logic [15:0] cap_w;
  logic [7:0]  cap_f;

  always @(negedge CLK) begin
    if (RST) begin
      cap_k = 8;
    end else begin
      if (frame_start) begin
        fs_cyc.push_back(cyc);
        cap_k = 0;
      end
      if (cap_k < 8) begin
        cap_w[15-2*cap_k] = d1;
        cap_w[14-2*cap_k] = d0;
        cap_f[7-cap_k]    = fco;
        cap_k++;
        if (cap_k == 8) begin
          words.push_back(cap_w);
          fco_b.push_back(cap_f);
        end
      end
      if (underrun) ur_cyc.push_back(cyc);
    end
  end

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  task automatic push(input logic [15:0] w);
    int i;
    s_valid = 1'b1;
    s_data  = w;
    i = 0;
    while (!s_ready && i < 100) begin
      @(negedge CLK);
      i++;
    end
    check("push_accept", int'(s_ready), 1);
    @(negedge CLK);
    s_valid = 1'b0;
  endtask

  task automatic wait_fs(input int n);
    for (int i = 0; i < 3000 && fs_cyc.size() < n; i++) @(posedge CLK);
    check("wait_frame_starts", int'(fs_cyc.size() >= n), 1);
  endtask

  task automatic wait_words(input int n);
    for (int i = 0; i < 3000 && words.size() < n; i++) @(posedge CLK);
    check("wait_words", int'(words.size() >= n), 1);
  endtask

  task automatic wait_slot(input int k);
    int i;
    i = 0;
    @(negedge CLK);
    while (!frame_start && i < 200) begin
      @(negedge CLK);
      i++;
    end
    check("wait_slot", int'(frame_start), 1);
    repeat (k) @(negedge CLK);
  endtask

  int en_cyc, n0;

  initial begin
    repeat (3) @(negedge CLK);
    check("reset_outputs", int'({d1, d0, fco, frame_start, underrun, s_ready}), 0);
    RST = 1'b0;
    @(negedge CLK);
    check("idle_outputs", int'({d1, d0, fco, frame_start, underrun, s_ready}), 0);

    // Sync preamble, then prefetched first data word.
    en     = 1'b1;
    en_cyc = cyc;
    push(16'h8001);
    wait_fs(17);
    check("first_slot0_latency", fs_cyc[0] - en_cyc, 2);
    check("first_data_frame_at", fs_cyc[16] - en_cyc, 130);

    @(negedge CLK);
    push(16'h1234);
    push(16'h5678);
    push(16'h9ABC);
    wait_words(22);
    check("sync_word_first", int'(words[0]), 16'hA55A);
    check("sync_word_last", int'(words[15]), 16'hA55A);
    check("fco_sync_frame", int'(fco_b[0]), 8'hF0);
    check("word_8001", int'(words[16]), 16'h8001);
    check("fco_data_frame", int'(fco_b[16]), 8'hF0);
    check("word_1234", int'(words[17]), 16'h1234);
    check("word_5678", int'(words[18]), 16'h5678);
    check("word_9abc", int'(words[19]), 16'h9ABC);
    check("back_to_back_span", fs_cyc[19] - fs_cyc[16], 24);
    check("underrun_word", int'(words[20]), 0);
    check("underrun_with_fs", ur_cyc[0], fs_cyc[20]);
    check("underrun_spacing", ur_cyc[1] - ur_cyc[0], 8);

    // Single skew request in slot 3.
    wait_slot(3);
    skew_req = 1'b1;
    n0 = fs_cyc.size() - 1;
    @(negedge CLK);
    skew_req = 1'b0;
    wait_fs(n0 + 3);
    check("skew_period_9", fs_cyc[n0+1] - fs_cyc[n0], 9);
    check("skew_then_8", fs_cyc[n0+2] - fs_cyc[n0+1], 8);

    // Two requests in one frame coalesce into one blank slot.
    wait_slot(1);
    skew_req = 1'b1;
    n0 = fs_cyc.size() - 1;
    @(negedge CLK);
    skew_req = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    skew_req = 1'b1;
    @(negedge CLK);
    skew_req = 1'b0;
    wait_fs(n0 + 3);
    check("coalesce_period_9", fs_cyc[n0+1] - fs_cyc[n0], 9);
    check("coalesce_then_8", fs_cyc[n0+2] - fs_cyc[n0+1], 8);

    // Disable at slot 2 with a word left in the holding register.
    wait_slot(2);
    en = 1'b0;
    push(16'h00FF);
    check("en_low_slot3_fco", int'(fco), 1);
    repeat (4) @(negedge CLK);
    check("en_low_slot7_fco", int'(fco), 0);
    @(negedge CLK);
    check("en_low_idle", int'({d1, d0, fco, frame_start, underrun, s_ready}), 0);

    // Skew request in IDLE is discarded.
    skew_req = 1'b1;
    @(negedge CLK);
    skew_req = 1'b0;
    en = 1'b1;
    n0 = fs_cyc.size();
    wait_fs(n0 + 2);
    check("idle_skew_discarded", fs_cyc[n0+1] - fs_cyc[n0], 8);

    // Asynchronous reset mid-frame.
    wait_slot(5);
    #2;
    RST = 1'b1;
    #1;
    check("async_reset", int'({d1, d0, fco, frame_start, underrun, s_ready}), 0);
    en = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    check("post_reset_idle", int'({d1, d0, fco, frame_start, underrun, s_ready}), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
